bram_copy_master: RTL and testbench
===================================

Name: bram_copy_master

Overview:
Initiator for the 32-bit BRAM port protocol used by `my_bram`. Copies a block of LEN words from a source BRAM port to a destination BRAM port as a fully pipelined stream: one read issued per cycle, one write per cycle. Sits between the controller FSM and two `my_bram` instances. Its `done` pulse may drive the BRAM `done` dump input in simulation.

Parameters:
- BRAM_ADDR_WIDTH, 15: byte-address width of both ports (4x8192 words).
- LEN_WIDTH, 14: width of `len`; the maximum legal value is 8192.

Ports:
- BRAM_CLK, in, 1: the single clock, shared with both BRAMs.
- BRAM_RST, in, 1: synchronous, active-high reset. The top level also ties both BRAMs' BRAM_RST to this signal.
- start, in, 1: one-cycle request pulse; sampled only in IDLE.
- src_base, in, BRAM_ADDR_WIDTH: source byte address; bits [1:0] are ignored.
- dst_base, in, BRAM_ADDR_WIDTH: destination byte address; bits [1:0] are ignored.
- len, in, LEN_WIDTH: number of words to copy (0..8192).
- busy, out, 1: high from the cycle after `start` is accepted through the last write.
- done, out, 1: one-cycle completion pulse.
- SRC_BRAM_ADDR, out, BRAM_ADDR_WIDTH: source byte address.
- SRC_BRAM_EN, out, 1: source port enable.
- SRC_BRAM_WE, out, 4: source write enables; always 0.
- SRC_BRAM_WRDATA, out, 32: always 0.
- SRC_BRAM_RDDATA, in, 32: source read data.
- DST_BRAM_ADDR, out, BRAM_ADDR_WIDTH: destination byte address.
- DST_BRAM_EN, out, 1: destination port enable.
- DST_BRAM_WE, out, 4: destination byte write enables.
- DST_BRAM_WRDATA, out, 32: destination write data.
- DST_BRAM_RDDATA, in, 32: unused.

Behaviour:
- Reset:
  - All outputs go to 0 at the next edge and the FSM returns to IDLE.
  - Reset mid-copy aborts the copy with no `done` pulse; partial writes remain in the destination.
- Responder timing: address sampled at edge E; data presented on RDDATA after edge E+1. EN must stay high at E+1 so the responder's output register loads.
- States:
  - IDLE: on `start`, latch bases (with bits [1:0] forced to 0) and `len`. If len==0, go to DONE; otherwise go to READ.
  - READ: runs cycles 0..len-1, counted from the first cycle after `start`. In cycle k, SRC_BRAM_ADDR = src_base + 4k and SRC_BRAM_EN=1. After k=len-1, go to DRAIN.
  - DRAIN: holds SRC_BRAM_EN=1 for 2 more cycles, then drops it. Stays until the write pipeline is empty, then goes to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- Read tracking: a 2-deep valid shift register follows each issued read. The word read in cycle k appears on SRC_BRAM_RDDATA in cycle k+2.
- Write stage (registered outputs): in cycle k+3, DST_BRAM_EN=1, DST_BRAM_WE=4'hF, DST_BRAM_ADDR = dst_base + 4k, DST_BRAM_WRDATA = the word read in cycle k. In all other cycles EN and WE are 0.
- Cycle timing:
  - Last write is in cycle len+2.
  - `done` is in cycle len+3.
  - `busy` is high in cycles 0..len+2.
  - For len==0, `done` is in cycle 0 and `busy` stays low.
- Arithmetic:
  - Addresses are BRAM_ADDR_WIDTH bits and wrap modulo 2^BRAM_ADDR_WIDTH; there is no error on wrap.
  - The word counter is LEN_WIDTH bits.
  - len > 8192 is illegal and its behaviour is undefined.
- `start` while busy or in DONE is ignored; requests are not queued.
- A `start` in the same cycle as BRAM_RST is ignored.

Optional Feature:
- Macro: BRAM_COPY_CHECKSUM_EN.
- Defined:
  - Adds output `checksum[31:0]`, reset to 0 and cleared on each accepted `start`.
  - Each write adds DST_BRAM_WRDATA modulo 2^32, in the same cycle the write is presented.
  - The final value is stable when `done` is high and holds until the next `start`.
- Undefined: the port and adder are absent; behaviour is otherwise identical.

Decomposition:
- Shared package `bram_pkg`:
  - constants BRAM_RD_LATENCY=2, BRAM_WORD_BYTES=4, BRAM_DEPTH=8192;
  - state enum typedef `copy_state_t` {IDLE, READ, DRAIN, DONE}.
- One natural sub-module: `bram_rd_pipe`, a 2-stage valid/index delay line that aligns read indices with returning data. Everything else stays in the top FSM.

Test Plan:
- src_base=0x0000, dst_base=0x0100, len=4, source words 0x11111111..0x44444444:
  - DST writes in cycles 3..6 at 0x100, 0x104, 0x108, 0x10C with matching data;
  - `done` in cycle 7; `busy` high for cycles 0..6.
- len=0: `done` in cycle 0; SRC/DST EN never asserted; `busy` stays low.
- src_base=0x7FF8, len=4: source addresses 0x7FF8, 0x7FFC, 0x0000, 0x0004 (wrap); all 4 words copied correctly.
- `start` re-pulsed at cycle 2 of a len=8 copy: ignored; exactly 8 writes and one `done` pulse.
- BRAM_RST asserted in cycle 3 of a len=16 copy:
  - all outputs 0 from the next cycle, no `done`;
  - a new copy started afterwards completes normally.
- With BRAM_COPY_CHECKSUM_EN, copying {1, 2, 0xFFFFFFFF}: checksum=0x00000002 when `done` is high.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared constants and state type for the BRAM copy master and its read-alignment pipe.
package bram_pkg;

  localparam int BRAM_RD_LATENCY = 32'd2;
  localparam int BRAM_WORD_BYTES = 32'd4;
  localparam int BRAM_DEPTH      = 32'd8192;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } copy_state_t;

endpackage

// File: rtl/bram_rd_pipe.sv
// Valid/index delay line matching the BRAM read latency, so each word index
// arrives together with the data that was read for it.
module bram_rd_pipe
  import bram_pkg::*;
#(
  parameter int IDX_WIDTH = 14
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_vld,
  input  logic [IDX_WIDTH-1:0] i_idx,
  output logic                 o_first_vld,
  output logic                 o_vld,
  output logic [IDX_WIDTH-1:0] o_idx,
  output logic                 o_busy
);

  logic                 r_vld [BRAM_RD_LATENCY];
  logic [IDX_WIDTH-1:0] r_idx [BRAM_RD_LATENCY];
  logic                 w_any;

  // Shift issued-read tags down the pipe, one stage per clock.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BRAM_RD_LATENCY; i++) begin
        r_vld[i] <= 1'b0;
        r_idx[i] <= {IDX_WIDTH{1'b0}};
      end
    end else begin
      r_vld[0] <= i_vld;
      r_idx[0] <= i_idx;
      for (int i = 1; i < BRAM_RD_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  // Any read still in flight keeps the pipe busy.
  always_comb begin
    w_any = 1'b0;
    for (int i = 0; i < BRAM_RD_LATENCY; i++) begin
      w_any = w_any | r_vld[i];
    end
  end

  assign o_first_vld = r_vld[0];
  assign o_vld       = r_vld[BRAM_RD_LATENCY-1];
  assign o_idx       = r_idx[BRAM_RD_LATENCY-1];
  assign o_busy      = w_any;

endmodule

// File: rtl/bram_copy_master.sv
// Streaming BRAM-to-BRAM block copier: one read and one write per cycle.
// Optional running write checksum output enabled by BRAM_COPY_CHECKSUM_EN.
module bram_copy_master
  import bram_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = 15,
  parameter int LEN_WIDTH       = 14
) (
  input  logic                       BRAM_CLK,
  input  logic                       BRAM_RST,
  input  logic                       start,
  input  logic [BRAM_ADDR_WIDTH-1:0] src_base,
  input  logic [BRAM_ADDR_WIDTH-1:0] dst_base,
  input  logic [LEN_WIDTH-1:0]       len,
  output logic                       busy,
  output logic                       done,
  output logic [BRAM_ADDR_WIDTH-1:0] SRC_BRAM_ADDR,
  output logic                       SRC_BRAM_EN,
  output logic [3:0]                 SRC_BRAM_WE,
  output logic [31:0]                SRC_BRAM_WRDATA,
  input  logic [31:0]                SRC_BRAM_RDDATA,
  output logic [BRAM_ADDR_WIDTH-1:0] DST_BRAM_ADDR,
  output logic                       DST_BRAM_EN,
  output logic [3:0]                 DST_BRAM_WE,
  output logic [31:0]                DST_BRAM_WRDATA,
  input  logic [31:0]                DST_BRAM_RDDATA
`ifdef BRAM_COPY_CHECKSUM_EN
  ,
  output logic [31:0]                checksum
`endif
);

  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_STEP = BRAM_ADDR_WIDTH'(BRAM_WORD_BYTES);
  localparam logic [LEN_WIDTH-1:0]       LEN_ONE   = LEN_WIDTH'(32'd1);

  copy_state_t                r_state;
  copy_state_t                w_state_nxt;
  logic [BRAM_ADDR_WIDTH-1:0] r_src_addr;
  logic [BRAM_ADDR_WIDTH-1:0] r_dst_base;
  logic [LEN_WIDTH-1:0]       r_len;
  logic [LEN_WIDTH-1:0]       r_cnt;
  logic                       r_src_en;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_dst_en;
  logic [3:0]                 r_dst_we;
  logic [BRAM_ADDR_WIDTH-1:0] r_dst_addr;
  logic [31:0]                r_dst_wrdata;

  logic                       w_start_ok;
  logic                       w_issue;
  logic                       w_last_rd;
  logic                       w_pipe_first;
  logic                       w_pipe_vld;
  logic [LEN_WIDTH-1:0]       w_pipe_idx;
  logic                       w_pipe_busy;
  logic [BRAM_ADDR_WIDTH-1:0] w_src_base_al;
  logic [BRAM_ADDR_WIDTH-1:0] w_dst_base_al;
  logic [BRAM_ADDR_WIDTH-1:0] w_dst_off;
  logic                       w_unused;

  assign w_start_ok    = (r_state == IDLE) && start;
  assign w_issue       = (r_state == READ);
  assign w_last_rd     = (r_cnt == (r_len - LEN_ONE));
  assign w_src_base_al = {src_base[BRAM_ADDR_WIDTH-1:2], 2'b00};
  assign w_dst_base_al = {dst_base[BRAM_ADDR_WIDTH-1:2], 2'b00};
  assign w_dst_off     = BRAM_ADDR_WIDTH'({w_pipe_idx, 2'b00});
  assign w_unused      = ^{DST_BRAM_RDDATA, src_base[1:0], dst_base[1:0]};

  bram_rd_pipe #(
    .IDX_WIDTH (LEN_WIDTH)
  ) u_rd_pipe (
    .i_clk       (BRAM_CLK),
    .i_rst       (BRAM_RST),
    .i_vld       (w_issue),
    .i_idx       (r_cnt),
    .o_first_vld (w_pipe_first),
    .o_vld       (w_pipe_vld),
    .o_idx       (w_pipe_idx),
    .o_busy      (w_pipe_busy)
  );

  // Next-state decode; DRAIN waits until no read is left in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (len == {LEN_WIDTH{1'b0}}) ? DONE : READ;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      READ: begin
        if (w_last_rd) begin
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = READ;
        end
      end
      DRAIN: begin
        if (!w_pipe_busy) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge BRAM_CLK) begin
    if (BRAM_RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Read side, status flags and the registered write stage.
  always_ff @(posedge BRAM_CLK) begin
    if (BRAM_RST) begin
      r_src_addr   <= {BRAM_ADDR_WIDTH{1'b0}};
      r_dst_base   <= {BRAM_ADDR_WIDTH{1'b0}};
      r_len        <= {LEN_WIDTH{1'b0}};
      r_cnt        <= {LEN_WIDTH{1'b0}};
      r_src_en     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_dst_en     <= 1'b0;
      r_dst_we     <= 4'h0;
      r_dst_addr   <= {BRAM_ADDR_WIDTH{1'b0}};
      r_dst_wrdata <= 32'h0000_0000;
    end else begin
      r_busy   <= (w_state_nxt == READ) || (w_state_nxt == DRAIN);
      r_done   <= (w_state_nxt == DONE);
      // Enable stays up two cycles past the last read so its output register loads.
      r_src_en <= (w_state_nxt == READ) || w_issue || w_pipe_first;
      if (w_start_ok) begin
        r_src_addr <= w_src_base_al;
        r_dst_base <= w_dst_base_al;
        r_len      <= len;
        r_cnt      <= {LEN_WIDTH{1'b0}};
      end else if (w_issue && !w_last_rd) begin
        r_src_addr <= r_src_addr + ADDR_STEP;
        r_cnt      <= r_cnt + LEN_ONE;
      end
      r_dst_en <= w_pipe_vld;
      r_dst_we <= w_pipe_vld ? 4'hF : 4'h0;
      if (w_pipe_vld) begin
        r_dst_addr   <= r_dst_base + w_dst_off;
        r_dst_wrdata <= SRC_BRAM_RDDATA;
      end
    end
  end

`ifdef BRAM_COPY_CHECKSUM_EN
  logic [31:0] r_checksum;

  // Sum advances on the same edge that presents the write it covers.
  always_ff @(posedge BRAM_CLK) begin
    if (BRAM_RST) begin
      r_checksum <= 32'h0000_0000;
    end else if (w_start_ok) begin
      r_checksum <= 32'h0000_0000;
    end else if (w_pipe_vld) begin
      r_checksum <= r_checksum + SRC_BRAM_RDDATA;
    end
  end

  assign checksum = r_checksum;
`endif

  assign busy            = r_busy;
  assign done            = r_done;
  assign SRC_BRAM_ADDR   = r_src_addr;
  assign SRC_BRAM_EN     = r_src_en;
  assign SRC_BRAM_WE     = 4'h0;
  assign SRC_BRAM_WRDATA = 32'h0000_0000;
  assign DST_BRAM_ADDR   = r_dst_addr;
  assign DST_BRAM_EN     = r_dst_en;
  assign DST_BRAM_WE     = r_dst_we;
  assign DST_BRAM_WRDATA = r_dst_wrdata;

endmodule

// File: tb/tb_bram_copy_master.sv
// Self-checking bench for bram_copy_master: table rows, random copies, restart and reset corners.
module tb_bram_copy_master;
  import bram_pkg::*;

  localparam int AW = 15;
  localparam int LW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_base;
  logic [AW-1:0] dst_base;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic [AW-1:0] src_addr;
  logic          src_en;
  logic [3:0]    src_we;
  logic [31:0]   src_wrdata;
  logic [31:0]   src_rddata;
  logic [AW-1:0] dst_addr;
  logic          dst_en;
  logic [3:0]    dst_we;
  logic [31:0]   dst_wrdata;
  logic [31:0]   dst_rddata;
`ifdef BRAM_COPY_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  bram_copy_master #(.BRAM_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .BRAM_CLK        (clk),
    .BRAM_RST        (rst),
    .start           (start),
    .src_base        (src_base),
    .dst_base        (dst_base),
    .len             (len),
    .busy            (busy),
    .done            (done),
    .SRC_BRAM_ADDR   (src_addr),
    .SRC_BRAM_EN     (src_en),
    .SRC_BRAM_WE     (src_we),
    .SRC_BRAM_WRDATA (src_wrdata),
    .SRC_BRAM_RDDATA (src_rddata),
    .DST_BRAM_ADDR   (dst_addr),
    .DST_BRAM_EN     (dst_en),
    .DST_BRAM_WE     (dst_we),
    .DST_BRAM_WRDATA (dst_wrdata),
    .DST_BRAM_RDDATA (dst_rddata)
`ifdef BRAM_COPY_CHECKSUM_EN
    ,
    .checksum        (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Two-register BRAM responders: address at edge E, data visible after E+1.
  logic [31:0] src_mem [BRAM_DEPTH];
  logic [31:0] dst_mem [BRAM_DEPTH];
  logic [31:0] src_q;

  always @(posedge clk) begin
    if (src_en) begin
      src_q      <= src_mem[src_addr[AW-1:2]];
      src_rddata <= src_q;
    end
  end

  always @(posedge clk) begin
    if (dst_en) begin
      for (int b = 0; b < 4; b++) begin
        if (dst_we[b]) dst_mem[dst_addr[AW-1:2]][8*b +: 8] <= dst_wrdata[8*b +: 8];
      end
      dst_rddata <= dst_mem[dst_addr[AW-1:2]];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill_src();
    for (int i = 0; i < BRAM_DEPTH; i++) src_mem[i] = $urandom;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'h0);
    chk({tag, " done"}, 32'(done), 32'h0);
    chk({tag, " src_en"}, 32'(src_en), 32'h0);
    chk({tag, " src_addr"}, 32'(src_addr), 32'h0);
    chk({tag, " dst_en"}, 32'(dst_en), 32'h0);
    chk({tag, " dst_we"}, 32'(dst_we), 32'h0);
    chk({tag, " dst_addr"}, 32'(dst_addr), 32'h0);
    chk({tag, " dst_wrdata"}, dst_wrdata, 32'h0);
`ifdef BRAM_COPY_CHECKSUM_EN
    chk({tag, " checksum"}, checksum, 32'h0);
`endif
  endtask

  // Run one copy and check every cycle against the timing rules of the copier.
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                          input int restart_at, output int n_wr, output int done_cyc,
                          output int n_done, output logic [AW-1:0] last_dst, output logic [31:0] cs);
    logic [AW-1:0] s_al, d_al, e_addr;
    logic [31:0]   exp_sum, e_data;
    bit            e_busy, e_done, e_sen, e_den;
    string         t;
    s_al = {s[AW-1:2], 2'b00};
    d_al = {d[AW-1:2], 2'b00};
    exp_sum = 32'h0;
    for (int i = 0; i < n; i++) exp_sum += src_mem[(int'(s_al[AW-1:2]) + i) % BRAM_DEPTH];
    n_wr = 0; done_cyc = -1; n_done = 0; last_dst = '0; cs = 32'h0;
    @(negedge clk);
    src_base = s; dst_base = d; len = LW'(n); start = 1'b1;
    for (int c = 0; c <= n + 5; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      if (c == 0) begin
        src_base = AW'($urandom); dst_base = AW'($urandom); len = LW'($urandom_range(1, 8192));
      end
      t      = $sformatf("s%h d%h n%0d c%0d", s, d, n, c);
      e_busy = (n != 0) && (c <= n + 2);
      e_done = (n == 0) ? (c == 0) : (c == n + 3);
      e_sen  = (n != 0) && (c <= n + 1);
      e_den  = (n != 0) && (c >= 3) && (c <= n + 2);
      chk({t, " busy"}, 32'(busy), 32'(e_busy));
      chk({t, " done"}, 32'(done), 32'(e_done));
      chk({t, " src_en"}, 32'(src_en), 32'(e_sen));
      chk({t, " src_we"}, 32'(src_we), 32'h0);
      chk({t, " src_wrdata"}, src_wrdata, 32'h0);
      chk({t, " dst_en"}, 32'(dst_en), 32'(e_den));
      chk({t, " dst_we"}, 32'(dst_we), e_den ? 32'hF : 32'h0);
      if (c < n) begin
        e_addr = s_al + AW'(4 * c);
        chk({t, " src_addr"}, 32'(src_addr), 32'(e_addr));
      end
      if (e_den) begin
        e_addr = d_al + AW'(4 * (c - 3));
        e_data = src_mem[(int'(s_al[AW-1:2]) + c - 3) % BRAM_DEPTH];
        chk({t, " dst_addr"}, 32'(dst_addr), 32'(e_addr));
        chk({t, " dst_wrdata"}, dst_wrdata, e_data);
      end
      if (dst_en) begin
        n_wr++;
        last_dst = dst_addr;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
`ifdef BRAM_COPY_CHECKSUM_EN
        cs = checksum;
        chk({t, " checksum"}, checksum, exp_sum);
`endif
      end
    end
    for (int i = 0; i < n; i++) begin
      chk($sformatf("s%h d%h n%0d dstmem%0d", s, d, n, i),
          dst_mem[(int'(d_al[AW-1:2]) + i) % BRAM_DEPTH],
          src_mem[(int'(s_al[AW-1:2]) + i) % BRAM_DEPTH]);
    end
  endtask

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    int            len;
    int            exp_wr;
    int            exp_done;
    logic [AW-1:0] exp_last;
  } vec_t;

  vec_t          vecs[6];
  int            nw, dc, nd;
  logic [AW-1:0] ld;
  logic [31:0]   cs;

  initial begin
    vecs[0] = '{15'h0000, 15'h0100, 4, 4, 7, 15'h010C};
    vecs[1] = '{15'h7FF8, 15'h0200, 4, 4, 7, 15'h020C};
    vecs[2] = '{15'h0003, 15'h1002, 3, 3, 6, 15'h1008};
    vecs[3] = '{15'h1234, 15'h4000, 1, 1, 4, 15'h4000};
    vecs[4] = '{15'h0010, 15'h7FFC, 2, 2, 5, 15'h0000};
    vecs[5] = '{15'h0000, 15'h0100, 0, 0, 0, 15'h0000};

    rst = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; len = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      fill_src();
      if (i == 0) begin
        for (int j = 0; j < 4; j++) src_mem[j] = 32'h1111_1111 * (j + 1);
      end
      run_copy(vecs[i].src, vecs[i].dst, vecs[i].len, -1, nw, dc, nd, ld, cs);
      chk($sformatf("vec%0d writes", i), 32'(nw), 32'(vecs[i].exp_wr));
      chk($sformatf("vec%0d done_cycle", i), 32'(dc), 32'(vecs[i].exp_done));
      chk($sformatf("vec%0d done_count", i), 32'(nd), 32'd1);
      chk($sformatf("vec%0d last_dst", i), 32'(ld), 32'(vecs[i].exp_last));
    end

    // start re-pulsed in cycle 2 of a len=8 copy must be ignored
    fill_src();
    run_copy(15'h0040, 15'h0800, 8, 2, nw, dc, nd, ld, cs);
    chk("restart writes", 32'(nw), 32'd8);
    chk("restart done_count", 32'(nd), 32'd1);
    chk("restart done_cycle", 32'(dc), 32'd11);

    // reset in cycle 3 of a len=16 copy, with a start in the same cycle
    fill_src();
    @(negedge clk);
    src_base = 15'h0000; dst_base = 15'h2000; len = 14'd16; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    rst = 1'b0; start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("postreset c%0d done", c), 32'(done), 32'h0);
      chk($sformatf("postreset c%0d busy", c), 32'(busy), 32'h0);
      chk($sformatf("postreset c%0d src_en", c), 32'(src_en), 32'h0);
    end
    run_copy(15'h0020, 15'h2000, 5, -1, nw, dc, nd, ld, cs);
    chk("after_reset writes", 32'(nw), 32'd5);
    chk("after_reset done_cycle", 32'(dc), 32'd8);

`ifdef BRAM_COPY_CHECKSUM_EN
    fill_src();
    src_mem[0] = 32'h0000_0001; src_mem[1] = 32'h0000_0002; src_mem[2] = 32'hFFFF_FFFF;
    run_copy(15'h0000, 15'h0300, 3, -1, nw, dc, nd, ld, cs);
    chk("checksum_wrap", cs, 32'h0000_0002);
`endif

    // random copies, including short and empty lengths
    for (int r = 0; r < 10; r++) begin
      int n;
      fill_src();
      n = (r == 0) ? 0 : int'($urandom_range(1, 48));
      run_copy(AW'($urandom), AW'($urandom), n, -1, nw, dc, nd, ld, cs);
      chk($sformatf("rand%0d writes", r), 32'(nw), 32'(n));
      chk($sformatf("rand%0d done_cycle", r), 32'(dc), (n == 0) ? 32'd0 : 32'(n + 3));
    end

    // maximum legal length
    fill_src();
    run_copy(15'h0004, 15'h0008, BRAM_DEPTH, -1, nw, dc, nd, ld, cs);
    chk("maxlen writes", 32'(nw), 32'(BRAM_DEPTH));
    chk("maxlen done_cycle", 32'(dc), 32'(BRAM_DEPTH + 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
